// File: rtl/ring_output_arbiter.sv
// Round-robin output-port arbiter for the mesh/ring router: polarity-gated VCs, one-entry
// output register with send/ready handshake, hop decrement. Optional grant counter: RING_ARB_GRANT_CNT_EN.
module ring_output_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int HOP_MSB = 55,
    parameter int HOP_LSB = 48
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      polarity,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_vc,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      so,
    input  logic                      ro,
    output logic [DATA_W-1:0]         do_data,
    output logic                      busy
`ifdef RING_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]               grant_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int EXT_N = 1 << PTR_W;
    localparam int HOP_W = HOP_MSB - HOP_LSB + 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W-1:0]    win_idx_s;
    logic                win_found_s;
    logic [EXT_N-1:0]    elig_ext_s;
    logic                cap_s;
    logic                grant_s;
    logic [DATA_W-1:0]   win_data_s;
    logic [DATA_W-1:0]   do_r;

    // Hop count decrements on departure but never wraps below zero.
    function automatic logic [DATA_W-1:0] hop_dec(input logic [DATA_W-1:0] pkt);
        logic [DATA_W-1:0] res;
        logic [HOP_W-1:0]  hop;
        res = pkt;
        hop = pkt[HOP_MSB:HOP_LSB];
        if (hop != {HOP_W{1'b0}}) begin
            res[HOP_MSB:HOP_LSB] = hop - HOP_W'(1);
        end else begin
            res = pkt;
        end
        return res;
    endfunction

    // Eligibility (request on the current phase's VC) and output capacity.
    always_comb begin
        elig_ext_s                = '0;
        elig_ext_s[NUM_REQ-1:0]   = req & ~(req_vc ^ {NUM_REQ{polarity}});
        cap_s                     = (state_r == IDLE) || ((state_r == SEND) && ro);
    end

    // Rotating scan starting just after the last winner.
    always_comb begin
        logic [SUM_W-1:0] sum_v;
        sum_v       = '0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_v = {1'b0, ptr_r} + SUM_W'(k);
            if (sum_v >= SUM_W'(NUM_REQ)) begin
                sum_v = sum_v - SUM_W'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            if (!win_found_s && elig_ext_s[sum_v[PTR_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = sum_v[PTR_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // One-hot grant and winner data mux; reset suppresses grants so held packets are dropped.
    always_comb begin
        grant_s    = reset && cap_s && win_found_s;
        gnt        = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s && (win_idx_s == PTR_W'(i))) begin
                gnt[i]     = 1'b1;
                win_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                gnt[i]     = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a grant always refills the register; a stalled SEND holds.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (!ro || grant_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs decode the state register only, so ro never reaches so combinationally.
    always_comb begin
        so   = 1'b0;
        busy = 1'b0;
        case (state_r)
            IDLE: begin
                so   = 1'b0;
                busy = 1'b0;
            end
            SEND: begin
                so   = 1'b1;
                busy = 1'b1;
            end
            default: begin
                so   = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    // Output register and round-robin pointer; both move only on a real grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            do_r  <= '0;
            ptr_r <= PTR_RST;
        end else if (grant_s) begin
            do_r  <= hop_dec(win_data_s);
            ptr_r <= win_idx_s;
        end else begin
            do_r  <= do_r;
            ptr_r <= ptr_r;
        end
    end

    assign do_data = do_r;

`ifdef RING_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt_r;

    // Saturating count of grants since reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt_r <= 16'h0000;
        end else if (grant_s && (grant_cnt_r != 16'hFFFF)) begin
            grant_cnt_r <= grant_cnt_r + 16'h0001;
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Directed bench for ring_output_arbiter: a scoreboard queue of expected packets is drained
// by a monitor on each completed transfer; grant/handshake state is checked inline.
module tb_ring_output_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;

    logic                      clk;
    logic                      reset;
    logic                      polarity;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_vc;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      so;
    logic                      ro;
    logic [DATA_W-1:0]         do_data;
    logic                      busy;
`ifdef RING_ARB_GRANT_CNT_EN
    logic [15:0]               grant_cnt;
`endif

    int total_cnt;
    int pass_cnt;
    logic [DATA_W-1:0] exp_q[$];

    ring_output_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .HOP_MSB(55),
        .HOP_LSB(48)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .polarity(polarity),
        .req     (req),
        .req_vc  (req_vc),
        .req_data(req_data),
        .gnt     (gnt),
        .so      (so),
        .ro      (ro),
        .do_data (do_data),
        .busy    (busy)
`ifdef RING_ARB_GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed transfer (so && ro at the coming edge) must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1 && so === 1'b1 && ro === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got %h expected no transfer", do_data);
            end else begin
                check("sb_data", do_data, exp_q.pop_front());
            end
        end
    end

    // One cycle: requesters pop on their grant edge, polarity flips every cycle.
    task automatic tick();
        logic [NUM_REQ-1:0] g;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        req      = req & ~g;
        polarity = ~polarity;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] d);
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        reset     = 1'b0;
        polarity  = 1'b0;
        req       = '0;
        req_vc    = '0;
        req_data  = '0;
        ro        = 1'b1;

        // Reset state
        do_reset();
        #1;
        check("rst_so", {63'd0, so}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_do", do_data, 64'd0);
`ifdef RING_ARB_GRANT_CNT_EN
        check("rst_cnt", {48'd0, grant_cnt}, 64'd0);
`endif

        // Single request, hop decrement, 1-cycle latency
        req[2] = 1'b1; req_vc[2] = polarity; set_data(2, 64'h0012_0000_000F_BA34);
        #1;
        check("single_gnt", {60'd0, gnt}, 64'h4);
        exp_q.push_back(64'h0011_0000_000F_BA34);
        tick(); #1;
        check("single_so", {63'd0, so}, 64'd1);
        check("single_do", do_data, 64'h0011_0000_000F_BA34);
        tick(); #1;
        check("single_idle", {63'd0, so}, 64'd0);

        // Hop zero passes through unchanged
        req[0] = 1'b1; req_vc[0] = polarity; set_data(0, 64'h0000_0000_000D_DA42);
        #1;
        check("hop0_gnt", {60'd0, gnt}, 64'h1);
        exp_q.push_back(64'h0000_0000_000D_DA42);
        tick(); #1;
        check("hop0_so", {63'd0, so}, 64'd1);
        tick(); #1;
        check("hop0_idle", {63'd0, so}, 64'd0);

        // Four-way contention on one VC from a fresh pointer
        do_reset();
        req = 4'b1111; req_vc = {NUM_REQ{polarity}};
        set_data(0, 64'h0005_0000_00AB_CDEF);
        set_data(1, 64'h0001_0000_1234_5678);
        set_data(2, 64'h00FF_0000_00DE_F123);
        set_data(3, 64'h0000_0000_0001_1A11);
        exp_q.push_back(64'h0004_0000_00AB_CDEF);
        exp_q.push_back(64'h0000_0000_1234_5678);
        exp_q.push_back(64'h00FE_0000_00DE_F123);
        exp_q.push_back(64'h0000_0000_0001_1A11);
        for (int c = 0; c < 8; c++) begin
            logic [3:0] eg;
            eg = (c % 2 == 0) ? (4'b0001 << (c / 2)) : 4'b0000;
            #1;
            check($sformatf("rr_gnt_c%0d", c), {60'd0, gnt}, {60'd0, eg});
            check($sformatf("rr_so_c%0d", c), {63'd0, so}, {63'd0, (c % 2 == 1)});
            tick();
        end
        #1;
        check("rr_idle", {63'd0, so}, 64'd0);

        // Polarity gating
        req[0] = 1'b1; req_vc[0] = ~polarity; set_data(0, 64'h0003_0000_0000_0044);
        #1;
        check("pol_block", {60'd0, gnt}, 64'h0);
        tick(); #1;
        check("pol_gnt", {60'd0, gnt}, 64'h1);
        exp_q.push_back(64'h0002_0000_0000_0044);
        tick(); tick();

        // Backpressure with a pending requester
        ro = 1'b0;
        req[2] = 1'b1; req_vc[2] = polarity; set_data(2, 64'h0009_0000_0000_0A0A);
        #1;
        check("bp_first_gnt", {60'd0, gnt}, 64'h4);
        exp_q.push_back(64'h0008_0000_0000_0A0A);
        tick();
        req[1] = 1'b1; req_vc[1] = ~polarity; set_data(1, 64'h0000_0000_0000_0B0B);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_gnt_c%0d", c), {60'd0, gnt}, 64'h0);
            check($sformatf("bp_so_c%0d", c), {63'd0, so}, 64'd1);
            check($sformatf("bp_do_c%0d", c), do_data, 64'h0008_0000_0000_0A0A);
            tick();
        end
        ro = 1'b1;
        #1;
        check("bp_release_gnt", {60'd0, gnt}, 64'h2);
        exp_q.push_back(64'h0000_0000_0000_0B0B);
        tick(); #1;
        check("b2b_so", {63'd0, so}, 64'd1);
        check("b2b_do", do_data, 64'h0000_0000_0000_0B0B);
        tick(); #1;
        check("b2b_idle", {63'd0, so}, 64'd0);
`ifdef RING_ARB_GRANT_CNT_EN
        check("cnt_before_rst", {48'd0, grant_cnt}, 64'd7);
`endif

        // Reset while a packet sits in SEND
        ro = 1'b0;
        req[3] = 1'b1; req_vc[3] = polarity; set_data(3, 64'h0007_0000_0000_0C0C);
        #1;
        check("rst_mid_gnt", {60'd0, gnt}, 64'h8);
        tick(); #1;
        check("rst_mid_so", {63'd0, so}, 64'd1);
        reset = 1'b0;
        req[0] = 1'b1; req_vc[0] = polarity;
        #1;
        check("rst_gnt_forced", {60'd0, gnt}, 64'h0);
        tick();
        reset = 1'b1;
        ro = 1'b1;
        #1;
        check("rst_mid_so_low", {63'd0, so}, 64'd0);
        check("rst_mid_do", do_data, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
`ifdef RING_ARB_GRANT_CNT_EN
        check("rst_mid_cnt", {48'd0, grant_cnt}, 64'd0);
`endif
        req = 4'b1111; req_vc = {NUM_REQ{polarity}};
        set_data(0, 64'h0000_0000_0000_0D0D);
        #1;
        check("rst_ptr_gnt", {60'd0, gnt}, 64'h1);
        req = 4'b0001;
        exp_q.push_back(64'h0000_0000_0000_0D0D);
        tick(); #1;
        check("post_rst_so", {63'd0, so}, 64'd1);
`ifdef RING_ARB_GRANT_CNT_EN
        check("post_rst_cnt", {48'd0, grant_cnt}, 64'd1);
`endif
        tick(); tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
